// File: rtl/alu_check_monitor.sv
// Self-checking monitor for a 32-bit ALU command interface.
// It recomputes each observed transaction with a golden model, counts checks and mismatches,
// and freezes the first failing transaction for debug.
// Pipeline: accept -> S1 (capture) -> S2 (golden/compare) -> counters (accept + 2).
module alu_check_monitor #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CNT_W       = 16,
  parameter bit          HALT_ON_ERR = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       command_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] result_i,
  input  logic             carryout_i,
  input  logic             overflow_i,
  input  logic             zero_i,
  output logic [CNT_W-1:0] chk_count_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic             err_valid_o,
  output logic [2:0]       err_command_o,
  output logic [WIDTH-1:0] err_a_o,
  output logic [WIDTH-1:0] err_b_o,
  output logic [WIDTH-1:0] err_result_o,
  output logic [WIDTH-1:0] err_expected_o,
  output logic             halted_o
);

  localparam logic [2:0] CmdAdd  = 3'd0;
  localparam logic [2:0] CmdSub  = 3'd1;
  localparam logic [2:0] CmdXor  = 3'd2;
  localparam logic [2:0] CmdSlt  = 3'd3;
  localparam logic [2:0] CmdAnd  = 3'd4;
  localparam logic [2:0] CmdNand = 3'd5;
  localparam logic [2:0] CmdOr   = 3'd6;
  localparam logic [2:0] CmdNor  = 3'd7;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

  state_e state_q, state_d;

  // Stage S1: raw transaction as observed
  logic             s1_valid_q;
  logic [2:0]       s1_cmd_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_res_q;
  logic             s1_co_q, s1_ov_q, s1_z_q;

  // Stage S2: compare outcome plus what the capture needs
  logic             s2_valid_q;
  logic             s2_mis_q;
  logic [2:0]       s2_cmd_q;
  logic [WIDTH-1:0] s2_a_q, s2_b_q, s2_res_q, s2_exp_q;

  logic [CNT_W-1:0] chk_count_q, chk_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             err_valid_q, err_valid_d;
  logic             capture;

  logic             accept;
  logic             is_sub, is_arith;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum_w;
  logic             ov_exp;
  logic [WIDTH-1:0] exp_r;
  logic             mismatch;

  assign in_ready_o = (state_q == StRun);
  assign halted_o   = (state_q == StHalt);
  // clear discards a same-cycle handshake
  assign accept     = in_valid_i && in_ready_o && !clear_i;

  // Golden model and comparison on the S1 contents
  always_comb begin
    is_sub   = (s1_cmd_q == CmdSub);
    is_arith = (s1_cmd_q == CmdAdd) || is_sub;
    b_op     = is_sub ? ~s1_b_q : s1_b_q;
    sum_w    = {1'b0, s1_a_q} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    ov_exp   = (s1_a_q[WIDTH-1] == b_op[WIDTH-1]) && (sum_w[WIDTH-1] != s1_a_q[WIDTH-1]);
    exp_r    = '0;
    unique case (s1_cmd_q)
      CmdAdd, CmdSub: exp_r = sum_w[WIDTH-1:0];
      CmdXor:         exp_r = s1_a_q ^ s1_b_q;
      CmdSlt:         exp_r[0] = ($signed(s1_a_q) < $signed(s1_b_q));
      CmdAnd:         exp_r = s1_a_q & s1_b_q;
      CmdNand:        exp_r = ~(s1_a_q & s1_b_q);
      CmdOr:          exp_r = s1_a_q | s1_b_q;
      CmdNor:         exp_r = ~(s1_a_q | s1_b_q);
      default:        exp_r = '0;
    endcase
    // carry/overflow are don't-care outside ADD/SUB
    mismatch = s1_valid_q &&
               ((s1_res_q != exp_r) || (s1_z_q != (exp_r == '0)) ||
                (is_arith && ((s1_co_q != sum_w[WIDTH]) || (s1_ov_q != ov_exp))));
  end

  // Run/drain/halt control: halting waits for in-flight work to be counted
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (HALT_ON_ERR && mismatch) state_d = StDrain;
      StDrain: if (!s1_valid_q && !s2_valid_q) state_d = StHalt;
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
    if (clear_i) state_d = StRun;
  end

  // Saturating counters and first-error capture, driven from S2
  always_comb begin
    chk_count_d = chk_count_q;
    err_count_d = err_count_q;
    err_valid_d = err_valid_q;
    capture     = 1'b0;
    if (s2_valid_q) begin
      if (chk_count_q != '1) chk_count_d = chk_count_q + CntOne;
      if (s2_mis_q) begin
        if (err_count_q != '1) err_count_d = err_count_q + CntOne;
        if (!err_valid_q) begin
          err_valid_d = 1'b1;
          capture     = 1'b1;
        end
      end
    end
    if (clear_i) begin
      chk_count_d = '0;
      err_count_d = '0;
      err_valid_d = 1'b0;
      capture     = 1'b0;
    end
  end

  // State, counters and pipeline valids
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      chk_count_q <= '0;
      err_count_q <= '0;
      err_valid_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      chk_count_q <= chk_count_d;
      err_count_q <= err_count_d;
      err_valid_q <= err_valid_d;
      s1_valid_q  <= accept;
      s2_valid_q  <= s1_valid_q && !clear_i;
    end
  end

  // Pipeline data: S1 loads on accept, S2 loads whenever S1 holds a transaction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_cmd_q <= '0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_res_q <= '0;
      s1_co_q  <= 1'b0;
      s1_ov_q  <= 1'b0;
      s1_z_q   <= 1'b0;
      s2_mis_q <= 1'b0;
      s2_cmd_q <= '0;
      s2_a_q   <= '0;
      s2_b_q   <= '0;
      s2_res_q <= '0;
      s2_exp_q <= '0;
    end else begin
      if (accept) begin
        s1_cmd_q <= command_i;
        s1_a_q   <= a_i;
        s1_b_q   <= b_i;
        s1_res_q <= result_i;
        s1_co_q  <= carryout_i;
        s1_ov_q  <= overflow_i;
        s1_z_q   <= zero_i;
      end
      if (s1_valid_q) begin
        s2_mis_q <= mismatch;
        s2_cmd_q <= s1_cmd_q;
        s2_a_q   <= s1_a_q;
        s2_b_q   <= s1_b_q;
        s2_res_q <= s1_res_q;
        s2_exp_q <= exp_r;
      end
    end
  end

  // First-error capture; cleared only by clear or reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_command_o  <= '0;
      err_a_o        <= '0;
      err_b_o        <= '0;
      err_result_o   <= '0;
      err_expected_o <= '0;
    end else if (clear_i) begin
      err_command_o  <= '0;
      err_a_o        <= '0;
      err_b_o        <= '0;
      err_result_o   <= '0;
      err_expected_o <= '0;
    end else if (capture) begin
      err_command_o  <= s2_cmd_q;
      err_a_o        <= s2_a_q;
      err_b_o        <= s2_b_q;
      err_result_o   <= s2_res_q;
      err_expected_o <= s2_exp_q;
    end
  end

  assign chk_count_o = chk_count_q;
  assign err_count_o = err_count_q;
  assign err_valid_o = err_valid_q;

endmodule

// File: tb/tb_alu_check_monitor.sv
// Bench for alu_check_monitor: three instances (halting, non-halting, 2-bit counters),
// scoreboard of expected outcomes pushed at drive time and retired at accept + 2.
module tb_alu_check_monitor;

  localparam int W = 32;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, XOR = 3'd2, SLT = 3'd3;
  localparam logic [2:0] AND = 3'd4, OR = 3'd6;
  localparam longint MaxS = 64'sd2147483647;
  localparam longint MinS = -64'sd2147483648;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [2:0]   clr, vld;
  logic [2:0]   cmd;
  logic [W-1:0] a, b, res;
  logic         co, ov, z;

  // instance 0: halting, 16-bit counters
  logic rdy_m, ev_m, hlt_m;
  logic [15:0] chk_m, err_m;
  logic [2:0] ecmd_m;
  logic [W-1:0] ea_m, eb_m, er_m, ex_m;
  // instance 1: non-halting
  logic rdy_n, ev_n, hlt_n;
  logic [15:0] chk_n, err_n;
  logic [2:0] ecmd_n;
  logic [W-1:0] ea_n, eb_n, er_n, ex_n;
  // instance 2: non-halting, 2-bit counters
  logic rdy_c, ev_c, hlt_c;
  logic [1:0] chk_c, err_c;
  logic [2:0] ecmd_c;
  logic [W-1:0] ea_c, eb_c, er_c, ex_c;

  alu_check_monitor u_dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr[0]), .in_valid_i(vld[0]), .in_ready_o(rdy_m),
    .command_i(cmd), .a_i(a), .b_i(b), .result_i(res), .carryout_i(co), .overflow_i(ov),
    .zero_i(z), .chk_count_o(chk_m), .err_count_o(err_m), .err_valid_o(ev_m),
    .err_command_o(ecmd_m), .err_a_o(ea_m), .err_b_o(eb_m), .err_result_o(er_m),
    .err_expected_o(ex_m), .halted_o(hlt_m)
  );

  alu_check_monitor #(.HALT_ON_ERR(1'b0)) u_dut_nh (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr[1]), .in_valid_i(vld[1]), .in_ready_o(rdy_n),
    .command_i(cmd), .a_i(a), .b_i(b), .result_i(res), .carryout_i(co), .overflow_i(ov),
    .zero_i(z), .chk_count_o(chk_n), .err_count_o(err_n), .err_valid_o(ev_n),
    .err_command_o(ecmd_n), .err_a_o(ea_n), .err_b_o(eb_n), .err_result_o(er_n),
    .err_expected_o(ex_n), .halted_o(hlt_n)
  );

  alu_check_monitor #(.CNT_W(2), .HALT_ON_ERR(1'b0)) u_dut_c2 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr[2]), .in_valid_i(vld[2]), .in_ready_o(rdy_c),
    .command_i(cmd), .a_i(a), .b_i(b), .result_i(res), .carryout_i(co), .overflow_i(ov),
    .zero_i(z), .chk_count_o(chk_c), .err_count_o(err_c), .err_valid_o(ev_c),
    .err_command_o(ecmd_c), .err_a_o(ea_c), .err_b_o(eb_c), .err_result_o(er_c),
    .err_expected_o(ex_c), .halted_o(hlt_c)
  );

  typedef struct {
    int         inst;
    logic       mis;
    logic [2:0] cmd;
    logic [31:0] a, b, res, expr;
  } sb_t;

  sb_t sb_q[$];
  int  m_chk[3], m_err[3], cap[3];
  bit  m_ev[3];
  logic [2:0]  m_ecmd[3];
  logic [31:0] m_ea[3], m_eb[3], m_er[3], m_ex[3];
  int  n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: wide signed arithmetic for overflow, unsigned compare for borrow
  function automatic void golden(input logic [2:0] c, input logic [31:0] x, y,
                                 output logic [31:0] r, output logic cf, output logic vf);
    logic [32:0] t;
    longint sx, sy, s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    cf = 1'b0;
    vf = 1'b0;
    r  = '0;
    case (c)
      3'd0: begin
        t = {1'b0, x} + {1'b0, y}; r = t[31:0]; cf = t[32];
        s = sx + sy; vf = (s > MaxS) || (s < MinS);
      end
      3'd1: begin
        r = x - y; cf = (x >= y);
        s = sx - sy; vf = (s > MaxS) || (s < MinS);
      end
      3'd2: r = x ^ y;
      3'd3: r = (sx < sy) ? 32'd1 : 32'd0;
      3'd4: r = x & y;
      3'd5: r = ~(x & y);
      3'd6: r = x | y;
      default: r = ~(x | y);
    endcase
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one beat to an instance; valid stays up until idle() so beats can stream
  task automatic send(input int inst, input bit push, input logic [2:0] c,
                      input logic [31:0] x, y, rr, input logic cc, vv, zz);
    logic [31:0] r;
    logic cf, vf;
    sb_t it;
    cmd = c; a = x; b = y; res = rr; co = cc; ov = vv; z = zz;
    vld = 3'b000;
    vld[inst] = 1'b1;
    if (push) begin
      golden(c, x, y, r, cf, vf);
      it.inst = inst; it.cmd = c; it.a = x; it.b = y; it.res = rr; it.expr = r;
      it.mis  = (rr != r) || (zz != (r == 32'd0)) || ((c <= 3'd1) && ((cc != cf) || (vv != vf)));
      sb_q.push_back(it);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic good(input int inst, input logic [2:0] c, input logic [31:0] x, y);
    logic [31:0] r;
    logic cf, vf;
    golden(c, x, y, r, cf, vf);
    if (c > 3'd1) begin
      cf = 1'($urandom_range(0, 1));
      vf = 1'($urandom_range(0, 1));
    end
    send(inst, 1'b1, c, x, y, r, cf, vf, (r == 32'd0));
  endtask

  task automatic idle();
    vld = 3'b000;
  endtask

  // Retire everything accepted so far into the per-instance model
  task automatic drain();
    sb_t it;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      if (m_chk[it.inst] < cap[it.inst]) m_chk[it.inst]++;
      if (it.mis) begin
        if (m_err[it.inst] < cap[it.inst]) m_err[it.inst]++;
        if (!m_ev[it.inst]) begin
          m_ev[it.inst] = 1'b1; m_ecmd[it.inst] = it.cmd; m_ea[it.inst] = it.a;
          m_eb[it.inst] = it.b; m_er[it.inst] = it.res; m_ex[it.inst] = it.expr;
        end
      end
    end
  endtask

  task automatic model_reset(input int inst);
    m_chk[inst] = 0; m_err[inst] = 0; m_ev[inst] = 1'b0; m_ecmd[inst] = '0;
    m_ea[inst] = '0; m_eb[inst] = '0; m_er[inst] = '0; m_ex[inst] = '0;
  endtask

  task automatic chk_counts(input int inst, input string tag);
    logic [63:0] oc, oe, ov_;
    case (inst)
      0: begin oc = 64'(chk_m); oe = 64'(err_m); ov_ = 64'(ev_m); end
      1: begin oc = 64'(chk_n); oe = 64'(err_n); ov_ = 64'(ev_n); end
      default: begin oc = 64'(chk_c); oe = 64'(err_c); ov_ = 64'(ev_c); end
    endcase
    check({tag, "_chk_count"}, oc, 64'(m_chk[inst]));
    check({tag, "_err_count"}, oe, 64'(m_err[inst]));
    check({tag, "_err_valid"}, ov_, 64'(m_ev[inst]));
  endtask

  task automatic chk_cap(input int inst, input string tag);
    if (inst == 0) begin
      check({tag, "_err_command"}, 64'(ecmd_m), 64'(m_ecmd[0]));
      check({tag, "_err_a"}, 64'(ea_m), 64'(m_ea[0]));
      check({tag, "_err_b"}, 64'(eb_m), 64'(m_eb[0]));
      check({tag, "_err_result"}, 64'(er_m), 64'(m_er[0]));
      check({tag, "_err_expected"}, 64'(ex_m), 64'(m_ex[0]));
    end else begin
      check({tag, "_err_command"}, 64'(ecmd_n), 64'(m_ecmd[1]));
      check({tag, "_err_a"}, 64'(ea_n), 64'(m_ea[1]));
      check({tag, "_err_b"}, 64'(eb_n), 64'(m_eb[1]));
      check({tag, "_err_result"}, 64'(er_n), 64'(m_er[1]));
      check({tag, "_err_expected"}, 64'(ex_n), 64'(m_ex[1]));
    end
  endtask

  initial begin
    logic [31:0] x, y;
    cap[0] = 65535; cap[1] = 65535; cap[2] = 3;
    for (int i = 0; i < 3; i++) model_reset(i);
    rst_n = 1'b0; clr = '0; vld = '0; cmd = '0; a = '0; b = '0; res = '0;
    co = 1'b0; ov = 1'b0; z = 1'b0;
    cycles(2);

    // Reset state
    check("rst_in_ready", 64'(rdy_m), 64'd1);
    check("rst_halted", 64'(hlt_m), 64'd0);
    chk_counts(0, "rst");
    chk_cap(0, "rst");
    rst_n = 1'b1;
    cycles(1);

    // T1: ADD with signed overflow, counted at accept + 2
    send(0, 1'b1, ADD, 32'h7ffffffe, 32'h00000002, 32'h80000000, 1'b0, 1'b1, 1'b0);
    idle();
    cycles(1);
    check("t1_latency_chk_count", 64'(chk_m), 64'd0);
    cycles(1);
    drain();
    chk_counts(0, "t1");
    check("t1_chk_const", 64'(chk_m), 64'd1);

    // T2: SUB with borrow then SLT signed, back to back
    send(0, 1'b1, SUB, 32'h7ffffffe, 32'h7fffffff, 32'hffffffff, 1'b0, 1'b0, 1'b0);
    send(0, 1'b1, SLT, 32'hffffffff, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0);
    idle();
    cycles(2);
    drain();
    chk_counts(0, "t2");
    check("t2_err_const", 64'(err_m), 64'd0);

    // Logic ops with junk carry/overflow (don't-care) and a zero result
    send(0, 1'b1, XOR, 32'h12345678, 32'h0f0f0f0f, 32'h12345678 ^ 32'h0f0f0f0f, 1'b1, 1'b1, 1'b0);
    for (int c = 4; c < 8; c++) good(0, 3'(c), $urandom, $urandom);
    good(0, AND, 32'h0f0f0f0f, 32'hf0f0f0f0);
    idle();
    cycles(2);
    drain();
    chk_counts(0, "logic_ops");

    // T3: XOR mismatch halts; the beat right behind it is still checked
    send(0, 1'b1, XOR, 32'haaaaaaaa, 32'h55555555, 32'hfffffffe, 1'b0, 1'b0, 1'b0);
    good(0, OR, 32'h00ff0000, 32'h000000ff);
    idle();
    check("t3_ready_drop", 64'(rdy_m), 64'd0);
    for (int i = 0; i < 8 && !hlt_m; i++) cycles(1);
    drain();
    check("t3_halted", 64'(hlt_m), 64'd1);
    check("t3_in_ready", 64'(rdy_m), 64'd0);
    check("t3_err_expected_const", 64'(ex_m), 64'hffffffff);
    check("t3_err_result_const", 64'(er_m), 64'hfffffffe);
    chk_counts(0, "t3");
    chk_cap(0, "t3");
    // Offered while halted: must be ignored
    send(0, 1'b0, ADD, 32'd1, 32'd1, 32'd5, 1'b0, 1'b0, 1'b0);
    idle();
    cycles(3);
    chk_counts(0, "t3_halted_ignore");

    // clear returns to RUN with everything zeroed
    clr[0] = 1'b1;
    cycles(1);
    clr[0] = 1'b0;
    model_reset(0);
    check("clr_halted", 64'(hlt_m), 64'd0);
    check("clr_in_ready", 64'(rdy_m), 64'd1);
    chk_counts(0, "clr");
    chk_cap(0, "clr");

    // T4: three back-to-back mismatches without halting; capture keeps the first
    send(1, 1'b1, ADD, 32'd5, 32'd3, 32'd9, 1'b0, 1'b0, 1'b0);
    send(1, 1'b1, SUB, 32'd5, 32'd3, 32'd2, 1'b0, 1'b0, 1'b0);
    send(1, 1'b1, OR, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    idle();
    cycles(2);
    drain();
    chk_counts(1, "t4");
    chk_cap(1, "t4");
    check("t4_err_const", 64'(err_n), 64'd3);
    check("t4_first_expected", 64'(ex_n), 64'd8);
    check("t4_halted", 64'(hlt_n), 64'd0);
    check("t4_in_ready", 64'(rdy_n), 64'd1);

    // T5: 2-bit counters saturate
    for (int i = 0; i < 5; i++) good(2, ADD, $urandom, $urandom);
    idle();
    cycles(2);
    drain();
    chk_counts(2, "t5_good");
    check("t5_chk_sat", 64'(chk_c), 64'd3);
    for (int i = 0; i < 4; i++) begin
      x = $urandom; y = $urandom;
      send(2, 1'b1, XOR, x, y, ~(x ^ y), 1'b0, 1'b0, 1'b0);
    end
    idle();
    cycles(2);
    drain();
    chk_counts(2, "t5_bad");
    // clear wins over a same-cycle handshake
    clr[2] = 1'b1;
    send(2, 1'b0, XOR, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0);
    clr[2] = 1'b0;
    idle();
    cycles(3);
    model_reset(2);
    chk_counts(2, "t5_clear");

    // T6: reset one cycle after accept loses the transaction
    good(0, ADD, 32'd10, 32'd20);
    idle();
    cycles(2);
    drain();
    chk_counts(0, "t6_pre");
    good(0, SUB, 32'd50, 32'd20);
    idle();
    cycles(1);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    for (int i = 0; i < 3; i++) model_reset(i);
    check("t6_in_ready", 64'(rdy_m), 64'd1);
    chk_counts(0, "t6_in_reset");
    cycles(1);
    rst_n = 1'b1;
    cycles(3);
    chk_counts(0, "t6_after");
    chk_counts(1, "t6_nh_after");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
